// File: rtl/core_arb_pkg.sv
// Shared types and constants for the two-requester core memory port arbiter.
package core_arb_pkg;

  localparam int NUM_REQ = 2;

  // Requester identifier: 0 = instruction port, 1 = data port.
  typedef logic id_t;

  localparam id_t ID_S0 = 1'b0;
  localparam id_t ID_S1 = 1'b1;

  // Arbitration state, grouped so it can be observed as one signal.
  typedef struct packed {
    logic lock;       // a presented request is waiting for m.gnt
    id_t  locked_id;  // owner of the presented request while lock=1
    id_t  last;       // most recently granted requester
  } arb_state_t;

endpackage

// File: rtl/core_if.sv
// Core memory port bundle: req/gnt request phase, rvalid response phase.
//
// Handshake: a request transfers in the cycle where req && gnt are both high;
// once req is raised, the requester holds req/we/be/addr/wdata stable until
// gnt. Responses return in request order, at the earliest one cycle after gnt,
// as a single-cycle rvalid pulse carrying rdata/err.
interface core_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Issues requests, receives grants and responses.
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  // Accepts requests, returns grants and responses.
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/core_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Pointers wrap modulo DEPTH; push on full and pop on empty are ignored.
module core_arb_id_fifo
  import core_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  id_t                        din,
  output id_t                        dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  id_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer, occupancy and storage update; reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/core_arbiter.sv
// 2:1 arbiter sharing one core memory port between an instruction requester
// (s0) and a data requester (s1). Granted IDs are queued in order so every
// response is routed back to its originator with no added latency.
// Optional build macro: CORE_ARBITER_FIXED_PRIO_EN makes s1 win every tie
// instead of round-robin; a request already presented without gnt still
// completes first.
module core_arbiter
  import core_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic   aclk,
  input  logic   areset,
  core_if.slave  s0,
  core_if.slave  s1,
  core_if.master m,
  output logic   protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t    state;
  id_t           sel;
  id_t           head_id;
  logic          sel_req;
  logic          m_req;
  logic          handshake;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;

  // Pick the requester that owns the downstream port this cycle.
  always_comb begin
    // Idle default: park on the requester that would win the next tie.
    sel = ~state.last;
    if (state.lock) begin
      sel = state.locked_id;
    end else if (s0.req && !s1.req) begin
      sel = ID_S0;
    end else if (s1.req && !s0.req) begin
      sel = ID_S1;
    end else if (s0.req && s1.req) begin
`ifdef CORE_ARBITER_FIXED_PRIO_EN
      sel = ID_S1;
`else
      sel = ~state.last;
`endif
    end
  end

  // Forward the selected request; a full ID FIFO blocks it even if a
  // response pops in the same cycle.
  always_comb begin
    sel_req = (sel == ID_S1) ? s1.req : s0.req;
    m_req   = sel_req && (count < CW'(MAX_OUTSTANDING));
    m.req   = m_req;
    m.we    = (sel == ID_S1) ? s1.we    : s0.we;
    m.be    = (sel == ID_S1) ? s1.be    : s0.be;
    m.addr  = (sel == ID_S1) ? s1.addr  : s0.addr;
    m.wdata = (sel == ID_S1) ? s1.wdata : s0.wdata;
  end

  // Grant back to the selected requester and route responses by FIFO head.
  always_comb begin
    handshake = m_req && m.gnt;
    s0.gnt    = handshake && (sel == ID_S0);
    s1.gnt    = handshake && (sel == ID_S1);
    pop       = m.rvalid && !fifo_empty;
    s0.rvalid = pop && (head_id == ID_S0);
    s1.rvalid = pop && (head_id == ID_S1);
    s0.rdata  = m.rdata;
    s1.rdata  = m.rdata;
    s0.err    = m.err;
    s1.err    = m.err;
  end

  // Lock a presented-but-ungranted request, remember the last winner and
  // flag responses that arrive with nothing outstanding.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state.lock      <= 1'b0;
      state.locked_id <= ID_S0;
      state.last      <= ID_S1;
      protocol_err    <= 1'b0;
    end else begin
      if (handshake) begin
        state.lock <= 1'b0;
        state.last <= sel;
      end else if (m_req) begin
        state.lock      <= 1'b1;
        state.locked_id <= sel;
      end
      if (m.rvalid && fifo_empty) begin
        protocol_err <= 1'b1;
      end
    end
  end

  core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (handshake),
    .pop   (pop),
    .din   (sel),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // The count gate on m.req must keep grants off a full FIFO.
  a_no_push_when_full : assert property (@(posedge aclk) disable iff (areset)
    !(fifo_full && handshake));

endmodule

// File: doc/core_arbiter.md
Name: core_arbiter

Overview:
- 2:1 arbiter sharing one core memory port between two requesters, e.g. Ibex instruction and data ports feeding a single AXI4-Lite bridge.
- Protocol on all ports is req/gnt/rvalid; responses return in request order.
- Tracks the requester ID of every granted transaction in an in-order ID FIFO and routes each response back to its originator.
- Sits between the core and the core-to-AXI4-Lite converter.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (ID FIFO depth, >=1).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- s0  core_if slave  modport  requester 0 (instruction): req, gnt, we, be[3:0], addr[31:0], wdata[31:0], rvalid, rdata[31:0], err.
- s1  core_if slave  modport  requester 1 (data): same signal set.
- m  core_if master  modport  shared downstream port: same signal set.
- protocol_err  output  1  sticky flag; m.rvalid arrived while no transaction was outstanding.

Behaviour:
- Reset values:
  - FIFO empty, count=0, lock=0, last=1 (s0 wins the first tie), protocol_err=0.
  - s0/s1 gnt=0 and rvalid=0; m.req=0.
- Selection (combinational):
  - If lock=1, sel=locked_id.
  - Else if exactly one sN.req is high, sel=that requester.
  - Else if both are high, sel=!last (round-robin).
- Request forwarding:
  - m.req = sel.req && (count < MAX_OUTSTANDING).
  - m.we/be/addr/wdata are muxed from sel.
  - sel.gnt = m.gnt && m.req; the other requester's gnt=0.
  - Full FIFO blocks new grants even if m.rvalid pops in the same cycle (no bypass).
- Lock:
  - When m.req=1 and m.gnt=0, set lock=1 and locked_id=sel, so the address stays stable per protocol.
  - Clear lock on the handshake.
  - While locked, the other requester cannot win.
- Handshake (m.req && m.gnt):
  - Push sel into the ID FIFO.
  - last <= sel.
- Response:
  - On m.rvalid with a non-empty FIFO, pop the head ID.
  - The head requester gets rvalid=1, rdata, err in the same cycle (zero added latency, combinational path).
  - The other requester gets rvalid=0.
  - rdata/err are driven to both requesters; only rvalid is qualified.
- Simultaneous push and pop: allowed when count < MAX; count is unchanged.
- m.rvalid with an empty FIFO:
  - Response is dropped; no requester sees rvalid.
  - protocol_err <= 1 and holds until reset.
- Response latency:
  - Minimum is one cycle after gnt.
  - m.rvalid in the same cycle as gnt is illegal; the arbiter does not route it to the new ID.
- Reset mid-transaction:
  - Outstanding IDs are discarded.
  - Any later m.rvalid is treated as the empty-FIFO case.
- Count width: $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro: CORE_ARBITER_FIXED_PRIO_EN.
- Defined:
  - s1 (data) always wins a tie; last is not used for selection.
  - Lock still applies, so an s0 request already presented without gnt completes first.
- Undefined: round-robin as described above.

Decomposition:
- Package core_arb_pkg:
  - NUM_REQ=2.
  - typedef logic id_t (requester ID).
  - localparam ID_S0=1'b0, ID_S1=1'b1.
- Sub-module core_arb_id_fifo:
  - Parameters: DEPTH, id_t entries.
  - Ports: push/pop/din/dout/full/empty/count, synchronous active-high reset.
- Arbitration, lock and response routing stay in core_arbiter.

Test Plan:
- Single s0 read: s0.req, addr=0x100; m.gnt=1 in cycle 0; m.rvalid in cycle 2 with rdata=0xDEADBEEF -> s0.gnt in cycle 0; s0.rvalid=1, rdata=0xDEADBEEF in cycle 2; s1 sees no gnt or rvalid.
- Tie, round-robin: both req continuously, m.gnt=1 always, m.rvalid one cycle after each gnt -> grant order s0,s1,s0,s1; responses route to the matching requester in order.
- Backpressure/lock: s0.req addr=0x200 with m.gnt=0 for 3 cycles; s1.req rises in cycle 1 -> m.addr stays 0x200 all 4 cycles; s0 granted in cycle 3; s1 granted next.
- Outstanding limit (MAX=2): two grants, no rvalid -> m.req=0 while the third request waits; after one m.rvalid (pop), m.req=1 in the next cycle.
- Error and spurious response: granted s1 write, m.rvalid with err=1 -> s1.rvalid=1, err=1. A further m.rvalid with the FIFO empty -> no requester rvalid; protocol_err=1 until areset.
- Fixed priority (CORE_ARBITER_FIXED_PRIO_EN): both req for 4 handshakes -> all four go to s1; s0 is granted only when s1.req=0.
